tl_a_channel_rr_arbiter: RTL and testbench
==========================================

// Module: tl_a_channel_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one TileLink A channel (the channel checked by the TL monitor) among N requesters.
//  Zero-latency combinational forward of the winner's fields.
//  Grant is locked across all beats of a multi-beat data message, so bursts are never interleaved.
//  Sits between the requester ports and the single A-channel slave/monitor tap.
// PARAMETERS
//  N          4   number of requesters (2..8)
//  BEAT_BYTES 8   bytes per data beat (power of 2)
//  MAX_SIZE   6   largest legal lg2(bytes); sets beat-counter width
//  DATA_W     64  data bus width (8*BEAT_BYTES)
// PORTS
//  clock        in   1         rising-edge clock
//  reset_n      in   1         synchronous reset, active-low
//  in_valid     in   N         per-requester A valid
//  in_ready     out  N         per-requester A ready
//  in_opcode    in   3*N       packed opcode, requester i at [3i+:3]
//  in_param     in   3*N       packed param
//  in_size      in   4*N       packed lg2 size
//  in_source    in   7*N       packed source id
//  in_address   in   14*N      packed address
//  in_mask      in   (DATA_W/8)*N  packed byte mask
//  in_data      in   DATA_W*N  packed data
//  in_corrupt   in   N         corrupt bits
//  out_valid    out  1         A valid to slave
//  out_ready    in   1         A ready from slave
//  out_opcode/param/size/source/address/mask/data/corrupt  out  (as above, x1)  muxed winner fields
//  out_grant    out  N         one-hot winner; 0 when no valid
//  starve_flag  out  N         starvation indication (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): state=IDLE, rr_ptr=0, beat_cnt=0, lock_idx=0. All outputs are combinational from state and inputs.
//    With every in_valid=0 under reset: out_valid=0, out_grant=0, in_ready=0, starve_flag=0.
//  - fire = out_valid & out_ready. out_valid never depends on out_ready.
//  - in_ready[i] = out_ready & out_grant[i]. Output fields = fields of the granted index; all-zero when none.
//  - beats(msg):
//      opcode in {0,1,2,3} (data-bearing) and size > lg2(BEAT_BYTES): 2^(size-lg2(BEAT_BYTES)).
//      Otherwise 1. size>MAX_SIZE is clamped to MAX_SIZE.
//  - IDLE:
//      winner = first valid index scanning rr_ptr, rr_ptr+1, ... mod N. out_valid = |in_valid.
//      On fire: rr_ptr <= winner+1 mod N.
//      If beats>1: lock_idx<=winner, beat_cnt<=beats-1, go BURST. Else stay IDLE.
//  - BURST:
//      out_grant = onehot(lock_idx) and out_valid = in_valid[lock_idx]. Other requesters get ready=0 even if valid.
//      On fire: beat_cnt<=beat_cnt-1. When beat_cnt==1 and fire: go IDLE.
//      rr_ptr does not change in BURST.
//  - Requester drops valid mid-burst: out_valid=0, lock is held; no timeout.
//  - Simultaneous valids in IDLE: exactly one granted; with a stalled slave (out_ready=0), the grant stays fixed.
//  - rr_ptr wraps N-1 -> 0. beat_cnt never underflows.
//  - reset_n low mid-burst: returns to IDLE next edge; the partial burst is abandoned.
// CONFIGURATION
//  TL_ARB_STARVE_CNT_EN defined:
//    - Per-requester 8-bit saturating wait counter.
//    - Counter increments each cycle in_valid[i]=1 & in_ready[i]=0; clears on that requester's fire or on reset.
//    - starve_flag[i] = (cnt[i] >= 8'd64).
//  TL_ARB_STARVE_CNT_EN undefined: no counters are instantiated and starve_flag is tied to 0.
// TESTING
//  1 Reset, in_valid=4'b1111, out_ready=1, all Get (opcode 4) -> grants in order 0,1,2,3,0 on five consecutive cycles.
//  2 BEAT_BYTES=8, req1 PutFull size=5 (4 beats) while req2 valid ->
//    out_grant=0010 for exactly 4 fires, then req2 is granted; in_ready[2]=0 throughout the burst.
//  3 out_ready=0 for 10 cycles with reqs 0 and 3 valid -> out_grant is stable at 0001 and no state changes; on release, req0 fires.
//  4 Assert reset_n=0 after the 2nd of 4 beats -> next cycle state is IDLE and rr_ptr=0; a new Get from req2 is granted immediately.
//  5 PutFull size=2 (< beat) and Get size=6 -> each is 1 beat with no lock; beat_cnt stays 0.
//  6 Macro on: req3 valid and blocked by continuous bursts for 64 cycles -> starve_flag[3]=1 on cycle 64, cleared the cycle after req3 fires.
//    Macro off: starve_flag stays 0.

Source files
------------

// File: rtl/tl_a_channel_rr_arbiter.sv
// Purpose : round-robin arbiter sharing one TileLink A channel among N requesters,
//           locking the grant across every beat of a multi-beat data message.
// Latency : zero cycles; the winner's fields are forwarded combinationally.
// Backpressure: out_ready is steered only to the granted requester (in_ready); a stalled
//           slave freezes both the grant and all arbiter state.
//
// Ports
//   clock, reset_n        rising-edge clock, synchronous active-low reset
//   in_valid / in_ready   per-requester handshake (N bits each)
//   in_opcode .. in_corrupt  packed per-requester A fields, requester i at [W*i +: W]
//   out_valid / out_ready handshake toward the single A-channel slave / monitor tap
//   out_opcode .. out_corrupt  fields of the granted requester, zero when nothing granted
//   out_grant             one-hot winner
//   starve_flag           per-requester starvation indication
//
// Optional feature macro: TL_ARB_STARVE_CNT_EN
//   defined   -> per-requester 8-bit saturating wait counters drive starve_flag
//   undefined -> no counters, starve_flag is tied to zero
module tl_a_channel_rr_arbiter #(
  parameter int N          = 4,
  parameter int BEAT_BYTES = 8,
  parameter int MAX_SIZE   = 6,
  parameter int DATA_W     = 8 * BEAT_BYTES
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [N-1:0]              in_valid,
  output logic [N-1:0]              in_ready,
  input  logic [3*N-1:0]            in_opcode,
  input  logic [3*N-1:0]            in_param,
  input  logic [4*N-1:0]            in_size,
  input  logic [7*N-1:0]            in_source,
  input  logic [14*N-1:0]           in_address,
  input  logic [(DATA_W/8)*N-1:0]   in_mask,
  input  logic [DATA_W*N-1:0]       in_data,
  input  logic [N-1:0]              in_corrupt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2:0]                out_opcode,
  output logic [2:0]                out_param,
  output logic [3:0]                out_size,
  output logic [6:0]                out_source,
  output logic [13:0]               out_address,
  output logic [DATA_W/8-1:0]       out_mask,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_corrupt,
  output logic [N-1:0]              out_grant,
  output logic [N-1:0]              starve_flag
);

  localparam int PW  = (N > 1) ? $clog2(N) : 1;
  localparam int LGB = $clog2(BEAT_BYTES);
  localparam int MW  = DATA_W / 8;
  // Wide enough to hold (max beats - 1); at least one bit.
  localparam int BW  = (MAX_SIZE > LGB) ? (MAX_SIZE - LGB + 1) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   lock_idx;
  logic [BW-1:0]   beat_cnt;

  logic [PW-1:0]   rr_winner;
  logic            rr_found;
  logic [PW-1:0]   sel_idx;
  logic            sel_vld;
  logic            gnt_any;
  logic            fire;
  logic            multi;
  logic [BW-1:0]   beats_m1;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping modulo N.
  always_comb begin
    int idx;
    rr_winner = '0;
    rr_found  = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      if (!rr_found && in_valid[idx]) begin
        rr_found  = 1'b1;
        rr_winner = PW'(idx);
      end
    end
  end

  // In BURST the grant is pinned to the locked requester even if it drops valid,
  // so nobody else can slip a message into the middle of the burst.
  always_comb begin
    if (state == BURST) begin
      sel_idx = lock_idx;
      sel_vld = in_valid[lock_idx];
      gnt_any = 1'b1;
    end else begin
      sel_idx = rr_winner;
      sel_vld = rr_found;
      gnt_any = rr_found;
    end
  end

  assign out_valid = sel_vld;
  assign fire      = sel_vld & out_ready;

  always_comb begin
    out_grant = '0;
    if (gnt_any) out_grant[sel_idx] = 1'b1;
  end

  assign in_ready = {N{out_ready}} & out_grant;

  // Field mux: fields of the granted requester, all zero when nothing is granted.
  always_comb begin
    int s;
    s           = int'(sel_idx);
    out_opcode  = '0;
    out_param   = '0;
    out_size    = '0;
    out_source  = '0;
    out_address = '0;
    out_mask    = '0;
    out_data    = '0;
    out_corrupt = 1'b0;
    if (gnt_any) begin
      out_opcode  = in_opcode[s*3 +: 3];
      out_param   = in_param[s*3 +: 3];
      out_size    = in_size[s*4 +: 4];
      out_source  = in_source[s*7 +: 7];
      out_address = in_address[s*14 +: 14];
      out_mask    = in_mask[s*MW +: MW];
      out_data    = in_data[s*DATA_W +: DATA_W];
      out_corrupt = in_corrupt[s];
    end
  end

  // Beat count of the message currently presented. Only data-bearing opcodes
  // (PutFull, PutPartial, Arithmetic, Logical: 0..3) larger than one beat span
  // multiple beats; oversized requests are clamped to MAX_SIZE.
  always_comb begin
    int sz;
    sz       = int'(out_size);
    if (sz > MAX_SIZE) sz = MAX_SIZE;
    multi    = (out_opcode <= 3'd3) && (sz > LGB);
    beats_m1 = '0;
    if (multi) beats_m1 = BW'((1 << (sz - LGB)) - 1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      lock_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            rr_ptr <= (rr_winner == PW'(N - 1)) ? '0 : rr_winner + 1'b1;
            if (multi) begin
              lock_idx <= rr_winner;
              beat_cnt <= beats_m1;
              state    <= BURST;
            end
          end
        end
        BURST: begin
          if (fire) begin
            // Guard against a zero count as well so beat_cnt can never wrap.
            if (beat_cnt <= BW'(1)) begin
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TL_ARB_STARVE_CNT_EN
  logic [7:0] wait_cnt [N];

  // Counts cycles a requester is valid but not accepted; saturates at 255 and
  // clears on that requester's own handshake.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (!reset_n) begin
        wait_cnt[i] <= '0;
      end else if (in_valid[i] && in_ready[i]) begin
        wait_cnt[i] <= '0;
      end else if (in_valid[i] && (wait_cnt[i] != 8'hFF)) begin
        wait_cnt[i] <= wait_cnt[i] + 8'd1;
      end
    end
  end

  always_comb begin
    starve_flag = '0;
    for (int i = 0; i < N; i++) starve_flag[i] = (wait_cnt[i] >= 8'd64);
  end
`else
  assign starve_flag = '0;
`endif

endmodule

// File: tb/tb_tl_a_channel_rr_arbiter.sv
// Bench for tl_a_channel_rr_arbiter: directed vectors, expected handshakes queued
// by the stimulus process and popped by a monitor on every fire at the falling edge.
module tb_tl_a_channel_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int MW = DW / 8;

  logic              clock;
  logic              reset_n;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_ready;
  logic [3*N-1:0]    in_opcode;
  logic [3*N-1:0]    in_param;
  logic [4*N-1:0]    in_size;
  logic [7*N-1:0]    in_source;
  logic [14*N-1:0]   in_address;
  logic [MW*N-1:0]   in_mask;
  logic [DW*N-1:0]   in_data;
  logic [N-1:0]      in_corrupt;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_opcode;
  logic [2:0]        out_param;
  logic [3:0]        out_size;
  logic [6:0]        out_source;
  logic [13:0]       out_address;
  logic [MW-1:0]     out_mask;
  logic [DW-1:0]     out_data;
  logic              out_corrupt;
  logic [N-1:0]      out_grant;
  logic [N-1:0]      starve_flag;

  tl_a_channel_rr_arbiter #(.N(N), .BEAT_BYTES(8), .MAX_SIZE(6), .DATA_W(DW)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_param(in_param), .in_size(in_size),
    .in_source(in_source), .in_address(in_address), .in_mask(in_mask),
    .in_data(in_data), .in_corrupt(in_corrupt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_param(out_param), .out_size(out_size),
    .out_source(out_source), .out_address(out_address), .out_mask(out_mask),
    .out_data(out_data), .out_corrupt(out_corrupt),
    .out_grant(out_grant), .starve_flag(starve_flag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0] grant;
    logic [6:0]   source;
    logic [DW-1:0] data;
    logic [2:0]   opcode;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic set_req(input int i, input logic v, input logic [2:0] op,
                         input logic [3:0] sz, input logic [DW-1:0] d);
    in_valid[i]           = v;
    in_opcode[3*i +: 3]   = op;
    in_param[3*i +: 3]    = 3'd0;
    in_size[4*i +: 4]     = sz;
    in_source[7*i +: 7]   = 7'(8'h10 + i);
    in_address[14*i +: 14] = 14'(i * 256);
    in_mask[MW*i +: MW]   = '1;
    in_data[DW*i +: DW]   = d;
    in_corrupt[i]         = 1'b0;
  endtask

  task automatic clear_all();
    in_valid = '0; in_opcode = '0; in_param = '0; in_size = '0; in_source = '0;
    in_address = '0; in_mask = '0; in_data = '0; in_corrupt = '0;
  endtask

  task automatic expect_fire(input int i, input logic [DW-1:0] d, input logic [2:0] op);
    exp_t e;
    e.grant  = N'(1 << i);
    e.source = 7'(8'h10 + i);
    e.data   = d;
    e.opcode = op;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every accepted beat must match the head of the expected queue.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_fire: got grant %b src %h, want no fire", out_grant, out_source);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_grant !== e.grant || out_source !== e.source ||
            out_data !== e.data || out_opcode !== e.opcode) begin
          n_bad++;
          $display("FAIL fire grant/src/data/op: got %b/%h/%h/%0d, want %b/%h/%h/%0d",
                   out_grant, out_source, out_data, out_opcode,
                   e.grant, e.source, e.data, e.opcode);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] starve_want;
    clear_all();
    reset_n   = 1'b0;
    out_ready = 1'b0;

    // Reset state with all requesters idle.
    @(negedge clock);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_grant", 64'(out_grant), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_starve", 64'(starve_flag), 64'd0);
    step();
    step();
    reset_n = 1'b1;

    // 1: four Gets always valid -> grants 0,1,2,3,0.
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'd4, 4'd3, 64'hA0 + 64'(i));
    for (int c = 0; c < 5; c++) begin
      expect_fire(c % N, 64'hA0 + 64'(c % N), 3'd4);
      step();
    end
    clear_all();

    // 2: req1 PutFull size 5 (4 beats) with req2 waiting; rr_ptr is 1 here.
    set_req(2, 1'b1, 3'd4, 4'd3, 64'hC2);
    for (int b = 0; b < 4; b++) begin
      set_req(1, 1'b1, 3'd0, 4'd5, 64'hB0 + 64'(b));
      expect_fire(1, 64'hB0 + 64'(b), 3'd0);
      @(negedge clock);
      chk("burst_ready2", 64'(in_ready[2]), 64'd0);
      step();
    end
    set_req(1, 1'b0, 3'd0, 4'd0, 64'd0);
    expect_fire(2, 64'hC2, 3'd4);
    step();
    clear_all();

    // Bring rr_ptr back to 0 with one Get from req3.
    set_req(3, 1'b1, 3'd4, 4'd3, 64'hD3);
    expect_fire(3, 64'hD3, 3'd4);
    step();
    clear_all();

    // 3: stalled slave with req0 and req3 valid -> grant pinned at 0001.
    out_ready = 1'b0;
    set_req(0, 1'b1, 3'd4, 4'd3, 64'hE0);
    set_req(3, 1'b1, 3'd4, 4'd3, 64'hE3);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      chk("stall_grant", 64'(out_grant), 64'b0001);
      step();
    end
    out_ready = 1'b1;
    expect_fire(0, 64'hE0, 3'd4);
    step();
    set_req(0, 1'b0, 3'd0, 4'd0, 64'd0);
    expect_fire(3, 64'hE3, 3'd4);
    step();
    clear_all();

    // 4: reset after 2 of 4 beats; burst abandoned, req2 Get granted at once.
    for (int b = 0; b < 2; b++) begin
      set_req(0, 1'b1, 3'd0, 4'd5, 64'hF0 + 64'(b));
      expect_fire(0, 64'hF0 + 64'(b), 3'd0);
      step();
    end
    clear_all();
    reset_n = 1'b0;
    @(negedge clock);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    step();
    reset_n = 1'b1;
    set_req(2, 1'b1, 3'd4, 4'd3, 64'h42);
    expect_fire(2, 64'h42, 3'd4);
    @(negedge clock);
    chk("postrst_grant", 64'(out_grant), 64'b0100);
    step();
    clear_all();

    // 5: PutFull size 2 and Get size 6 are single beats; req2 follows without lock.
    set_req(0, 1'b1, 3'd0, 4'd2, 64'h5A);
    set_req(1, 1'b1, 3'd4, 4'd6, 64'h5B);
    expect_fire(0, 64'h5A, 3'd0);
    step();
    set_req(0, 1'b0, 3'd0, 4'd0, 64'd0);
    expect_fire(1, 64'h5B, 3'd4);
    step();
    set_req(1, 1'b0, 3'd0, 4'd0, 64'd0);
    set_req(2, 1'b1, 3'd4, 4'd3, 64'h5C);
    expect_fire(2, 64'h5C, 3'd4);
    step();
    clear_all();

    // 6: req0 holds a burst lock (valid dropped) while req3 waits 64 cycles.
    set_req(0, 1'b1, 3'd0, 4'd5, 64'h70);
    expect_fire(0, 64'h70, 3'd0);
    step();
    set_req(0, 1'b0, 3'd0, 4'd5, 64'h70);
    set_req(3, 1'b1, 3'd4, 4'd3, 64'h73);
    for (int c = 0; c < 63; c++) step();
    @(negedge clock);
    chk("starve_63", 64'(starve_flag), 64'd0);
    chk("locked_out_valid", 64'(out_valid), 64'd0);
    step();
`ifdef TL_ARB_STARVE_CNT_EN
    starve_want = 4'b1000;
`else
    starve_want = 4'b0000;
`endif
    @(negedge clock);
    chk("starve_64", 64'(starve_flag), 64'(starve_want));
    for (int b = 1; b < 4; b++) begin
      set_req(0, 1'b1, 3'd0, 4'd5, 64'h70 + 64'(b));
      expect_fire(0, 64'h70 + 64'(b), 3'd0);
      step();
    end
    set_req(0, 1'b0, 3'd0, 4'd0, 64'd0);
    expect_fire(3, 64'h73, 3'd4);
    step();
    clear_all();
    @(negedge clock);
    chk("starve_clear", 64'(starve_flag), 64'd0);

    step();
    step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
